// File: rtl/mpx_pilot_sequencer.sv
// rtl/mpx_pilot_sequencer.sv - MPX pilot gain ramp and overload measurement sequencer
module mpx_pilot_sequencer #(
    parameter int GAIN_WIDTH  = 16,
    parameter int STAT_WIDTH  = 8,
    parameter int MEAS_WINDOW = 48000
) (
    input  logic                  mclk,
    input  logic                  reset,
    input  logic                  cmd_start,
    input  logic                  cmd_stop,
    input  logic                  clear_fault,
    input  logic [GAIN_WIDTH-1:0] target_gain,
    input  logic [GAIN_WIDTH-1:0] ramp_step,
    input  logic [15:0]           ramp_interval,
    input  logic [STAT_WIDTH-1:0] ovl_hi,
    input  logic [STAT_WIDTH-1:0] ovl_lo,
    input  logic [STAT_WIDTH-1:0] stat_min,
    input  logic [STAT_WIDTH-1:0] stat_max,
    input  logic [31:0]           stat_count,
    output logic [GAIN_WIDTH-1:0] pilot_gain,
    output logic [1:0]            stat_cfg,
    output logic [31:0]           stat_limit,
    output logic [2:0]            state,
    output logic                  busy,
    output logic                  fault
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_CLEAR     = 3'd2,
        S_MEASURE   = 3'd3,
        S_EVAL      = 3'd4,
        S_RAMP_DOWN = 3'd5
    } state_t;

    localparam logic [31:0] LP_WINDOW = 32'(MEAS_WINDOW);

    state_t                r_state, w_state_nxt;
    logic [GAIN_WIDTH-1:0] r_gain, w_gain_nxt;
    logic [GAIN_WIDTH-1:0] r_target, w_target_nxt;
    logic [15:0]           r_timer, w_timer_nxt;
    logic                  r_clr_cnt, w_clr_cnt_nxt;
    logic                  r_fault, w_fault_nxt;
    logic [1:0]            r_cfg, w_cfg_nxt;
    logic                  r_busy, w_busy_nxt;

    logic [GAIN_WIDTH-1:0] w_step;
    logic [GAIN_WIDTH:0]   w_sum;
    logic [GAIN_WIDTH-1:0] w_up;
    logic [GAIN_WIDTH-1:0] w_dn;
    logic                  w_overload;
    logic                  w_window_done;

    // A zero step would stall the ramp forever, so it behaves as a step of one.
    assign w_step        = (ramp_step == '0) ? {{(GAIN_WIDTH-1){1'b0}}, 1'b1} : ramp_step;
    assign w_sum         = {1'b0, r_gain} + {1'b0, w_step};
    assign w_up          = (w_sum >= {1'b0, r_target}) ? r_target : w_sum[GAIN_WIDTH-1:0];
    assign w_dn          = (r_gain > w_step) ? (r_gain - w_step) : '0;
    assign w_overload    = ($signed(stat_max) > $signed(ovl_hi)) || ($signed(stat_min) < $signed(ovl_lo));
    assign w_window_done = (stat_count >= LP_WINDOW);

    always_comb begin
        w_state_nxt   = r_state;
        w_gain_nxt    = r_gain;
        w_target_nxt  = r_target;
        w_timer_nxt   = r_timer;
        w_clr_cnt_nxt = r_clr_cnt;
        w_fault_nxt   = r_fault & ~clear_fault;

        if (cmd_stop && (r_state != S_IDLE)) begin
            w_state_nxt = S_RAMP_DOWN;
            w_timer_nxt = ramp_interval;
        end else if (cmd_start && !cmd_stop && !r_fault &&
                     ((r_state == S_IDLE) || (r_state == S_RAMP_DOWN))) begin
            w_state_nxt  = S_RAMP_UP;
            w_target_nxt = target_gain;
            w_timer_nxt  = ramp_interval;
        end else begin
            case (r_state)
                S_RAMP_UP: begin
                    if (r_timer == '0) begin
                        w_gain_nxt  = w_up;
                        w_timer_nxt = ramp_interval;
                        if (w_up == r_target) begin
                            w_state_nxt   = S_CLEAR;
                            w_clr_cnt_nxt = 1'b0;
                        end
                    end else begin
                        w_timer_nxt = r_timer - 16'd1;
                    end
                end
                S_RAMP_DOWN: begin
                    if (r_timer == '0) begin
                        w_gain_nxt  = w_dn;
                        w_timer_nxt = ramp_interval;
                        if (w_dn == '0) w_state_nxt = S_IDLE;
                    end else begin
                        w_timer_nxt = r_timer - 16'd1;
                    end
                end
                S_CLEAR: begin
                    if (r_clr_cnt) w_state_nxt = S_MEASURE;
                    else w_clr_cnt_nxt = 1'b1;
                end
                S_MEASURE: begin
                    if (w_window_done) w_state_nxt = S_EVAL;
                end
                S_EVAL: begin
                    if (w_overload) begin
                        w_fault_nxt = 1'b1;
                        w_timer_nxt = ramp_interval;
                        w_state_nxt = S_RAMP_DOWN;
                    end else begin
                        w_state_nxt   = S_CLEAR;
                        w_clr_cnt_nxt = 1'b0;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        // Stats controls follow the state being entered so they line up with it.
        case (w_state_nxt)
            S_CLEAR:   w_cfg_nxt = 2'b01;
            S_MEASURE: w_cfg_nxt = 2'b10;
            default:   w_cfg_nxt = 2'b00;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_gain    <= '0;
            r_target  <= '0;
            r_timer   <= '0;
            r_clr_cnt <= 1'b0;
            r_fault   <= 1'b0;
            r_cfg     <= 2'b00;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gain    <= w_gain_nxt;
            r_target  <= w_target_nxt;
            r_timer   <= w_timer_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
            r_fault   <= w_fault_nxt;
            r_cfg     <= w_cfg_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign state      = r_state;
    assign pilot_gain = r_gain;
    assign stat_cfg   = r_cfg;
    assign stat_limit = LP_WINDOW;
    assign busy       = r_busy;
    assign fault      = r_fault;

endmodule

// File: tb/tb_mpx_pilot_sequencer.sv
// tb/tb_mpx_pilot_sequencer.sv - scoreboard bench with behavioural model for mpx_pilot_sequencer
module tb_mpx_pilot_sequencer;

    localparam int MW = 48000;
    localparam int ST_IDLE = 0, ST_UP = 1, ST_CLR = 2, ST_MEAS = 3, ST_EVAL = 4, ST_DOWN = 5;

    logic        mclk;
    logic        reset;
    logic        cmd_start, cmd_stop, clear_fault;
    logic [15:0] target_gain, ramp_step, ramp_interval;
    logic [7:0]  ovl_hi, ovl_lo, stat_min, stat_max;
    logic [31:0] stat_count;
    logic [15:0] pilot_gain;
    logic [1:0]  stat_cfg;
    logic [31:0] stat_limit;
    logic [2:0]  state;
    logic        busy, fault;

    mpx_pilot_sequencer #(.GAIN_WIDTH(16), .STAT_WIDTH(8), .MEAS_WINDOW(MW)) dut (
        .mclk(mclk), .reset(reset), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .clear_fault(clear_fault), .target_gain(target_gain), .ramp_step(ramp_step),
        .ramp_interval(ramp_interval), .ovl_hi(ovl_hi), .ovl_lo(ovl_lo),
        .stat_min(stat_min), .stat_max(stat_max), .stat_count(stat_count),
        .pilot_gain(pilot_gain), .stat_cfg(stat_cfg), .stat_limit(stat_limit),
        .state(state), .busy(busy), .fault(fault)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    typedef struct {
        int st;
        int gain;
        int cfg;
        int bsy;
        int flt;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    int m_st, m_gain, m_tgt, m_timer, m_clr_cycles, m_fault;

    task automatic chk(input string name, input int got, input int exp_v);
        total++;
        if (got != exp_v) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp_v, $time);
        end
    endtask

    // One cycle of the reference behaviour, from the current inputs.
    task automatic model_step();
        int step, ri, g, nst, nflt;
        exp_t e;
        if (reset) begin
            m_st = ST_IDLE; m_gain = 0; m_tgt = 0; m_timer = 0; m_clr_cycles = 0; m_fault = 0;
        end else begin
            step = (ramp_step == 0) ? 1 : int'(ramp_step);
            ri   = int'(ramp_interval);
            nst  = m_st;
            nflt = clear_fault ? 0 : m_fault;
            if (cmd_stop && m_st != ST_IDLE) begin
                nst = ST_DOWN; m_timer = ri;
            end else if (cmd_start && !cmd_stop && m_fault == 0 && (m_st == ST_IDLE || m_st == ST_DOWN)) begin
                nst = ST_UP; m_tgt = int'(target_gain); m_timer = ri;
            end else if (m_st == ST_UP || m_st == ST_DOWN) begin
                if (m_timer > 0) m_timer--;
                else begin
                    m_timer = ri;
                    if (m_st == ST_UP) begin
                        g = (m_gain + step < m_tgt) ? m_gain + step : m_tgt;
                        m_gain = g;
                        if (g == m_tgt) begin nst = ST_CLR; m_clr_cycles = 0; end
                    end else begin
                        g = m_gain - step;
                        if (g < 0) g = 0;
                        m_gain = g;
                        if (g == 0) nst = ST_IDLE;
                    end
                end
            end else if (m_st == ST_CLR) begin
                m_clr_cycles++;
                if (m_clr_cycles == 2) nst = ST_MEAS;
            end else if (m_st == ST_MEAS) begin
                if (stat_count >= MW) nst = ST_EVAL;
            end else if (m_st == ST_EVAL) begin
                if (int'($signed(stat_max)) > int'($signed(ovl_hi)) ||
                    int'($signed(stat_min)) < int'($signed(ovl_lo))) begin
                    nflt = 1; m_timer = ri; nst = ST_DOWN;
                end else begin
                    nst = ST_CLR; m_clr_cycles = 0;
                end
            end
            m_st = nst;
            m_fault = nflt;
        end
        e.st   = m_st;
        e.gain = m_gain;
        e.cfg  = (m_st == ST_CLR) ? 1 : (m_st == ST_MEAS) ? 2 : 0;
        e.bsy  = (m_st != ST_IDLE) ? 1 : 0;
        e.flt  = m_fault;
        q.push_back(e);
    endtask

    task automatic tick();
        model_step();
        @(negedge mclk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    endtask

    task automatic pulse_stop();
        cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge mclk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("state", int'(state), e.st);
                chk("pilot_gain", int'(pilot_gain), e.gain);
                chk("stat_cfg", int'(stat_cfg), e.cfg);
                chk("busy", int'(busy), e.bsy);
                chk("fault", int'(fault), e.flt);
                chk("stat_limit", int'(stat_limit), MW);
            end
        end
    end

    initial begin : driver
        reset = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0; clear_fault = 1'b0;
        target_gain = 16'h0100; ramp_step = 16'h0040; ramp_interval = 16'd3;
        ovl_hi = 8'sd100; ovl_lo = -8'sd100; stat_min = -8'sd90; stat_max = 8'sd90;
        stat_count = 32'd0;
        ticks(2);
        reset = 1'b0;

        // ramp up to 0x100 in four steps, then pass and fail windows
        pulse_start();
        ticks(22);
        stat_count = MW; tick(); stat_count = 0;
        ticks(6);
        stat_max = 8'sd101;
        stat_count = MW + 5; tick(); stat_count = 0;
        ticks(22);
        stat_max = 8'sd90;
        pulse_start();
        ticks(3);
        clear_fault = 1'b1; tick(); clear_fault = 1'b0;
        pulse_start();
        ticks(24);

        // stop while measuring, then start and stop together from idle
        pulse_stop();
        ticks(20);
        cmd_start = 1'b1; cmd_stop = 1'b1; tick();
        cmd_start = 1'b0; cmd_stop = 1'b0;
        ticks(3);

        // saturating steps with zero interval
        ramp_step = 16'h0060; ramp_interval = 16'd0;
        pulse_start();
        ticks(6);
        reset = 1'b1; tick(); reset = 1'b0;
        ticks(2);

        // reset mid-ramp; stop mid-ramp at 0xC0
        ramp_step = 16'h0040; ramp_interval = 16'd1;
        pulse_start();
        ticks(3);
        reset = 1'b1; tick(); reset = 1'b0;
        pulse_start();
        ticks(6);
        pulse_stop();
        ticks(10);

        // randomized traffic
        for (int i = 0; i < 5000; i++) begin
            reset         = ($urandom_range(0, 599) == 0);
            cmd_start     = ($urandom_range(0, 9) == 0);
            cmd_stop      = ($urandom_range(0, 59) == 0);
            clear_fault   = ($urandom_range(0, 39) == 0);
            target_gain   = 16'($urandom_range(0, 16'hffff));
            ramp_step     = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 16'h3000));
            ramp_interval = 16'($urandom_range(0, 3));
            stat_count    = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(MW, MW + 100))
                                                        : 32'($urandom_range(0, MW - 1));
            stat_max      = 8'($urandom_range(60, 105));
            stat_min      = 8'(-$urandom_range(60, 105));
            tick();
        end
        reset = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0; clear_fault = 1'b0;
        ticks(2);
        @(posedge mclk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
